// File: rtl/axi_pkg.sv
// Shared AXI address-channel definitions.
// Field widths, packed-entry width and field bit offsets used by the
// address FIFO, the address decoder and the arbiter.
// Entry packing, MSB to LSB: id, addr, len, size, burst, lock, cache, prot.
package axi_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned SIZE_W  = 2;
  localparam int unsigned BURST_W = 2;
  localparam int unsigned LOCK_W  = 2;
  localparam int unsigned CACHE_W = 4;
  localparam int unsigned PROT_W  = 3;

  // Bit offsets (LSB position) of each field inside a packed entry.
  localparam int unsigned PROT_LSB  = 0;
  localparam int unsigned CACHE_LSB = PROT_LSB  + PROT_W;
  localparam int unsigned LOCK_LSB  = CACHE_LSB + CACHE_W;
  localparam int unsigned BURST_LSB = LOCK_LSB  + LOCK_W;
  localparam int unsigned SIZE_LSB  = BURST_LSB + BURST_W;
  localparam int unsigned LEN_LSB   = SIZE_LSB  + SIZE_W;
  localparam int unsigned ADDR_LSB  = LEN_LSB   + LEN_W;
  localparam int unsigned ID_LSB    = ADDR_LSB  + ADDR_W;

  function automatic int unsigned entry_w(input int unsigned tag_bits);
    return tag_bits + ID_LSB;
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/axi_addr_fifo_n_ptr_ctrl.sv
// Pointer / occupancy controller for axi_addr_fifo_n.
// Ports:
//   clk, rst (async active-low)
//   push, pop, flush        : requests from the FIFO user
//   wr_en                   : storage write strobe for this edge
//   wr_ptr, rd_ptr          : storage indices
//   count                   : occupancy
//   empty/full/almost_full  : decodes of the count register only
//   overflow/underflow      : sticky error flags, cleared by flush
module fifo_ptr_ctrl
  import axi_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AF_THRESH = 3,
  localparam int unsigned PTR_W    = $clog2(DEPTH),
  localparam int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  output logic             wr_en,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             overflow,
  output logic             underflow
);

  if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_bad_depth
    $error("fifo_ptr_ctrl: DEPTH must be a power of 2 and >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_thresh
    $error("fifo_ptr_ctrl: AF_THRESH must be in 1..DEPTH");
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             pop_ok, push_ok;

  assign empty       = (count_q == '0);
  assign full        = (count_q == CNT_W'(DEPTH));
  assign almost_full = (count_q >= CNT_W'(AF_THRESH));

  always_comb begin
    pop_ok      = pop & ~empty;
    // A push into a full FIFO is taken only when the head leaves this cycle.
    push_ok     = push & (~full | pop_ok);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    wr_en       = 1'b0;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      wr_en = push_ok;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      if (push & full & ~pop_ok) overflow_d  = 1'b1;
      if (pop & empty)           underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign wr_ptr    = wr_ptr_q;
  assign rd_ptr    = rd_ptr_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: rtl/axi_addr_fifo_n.sv
// Parametrised AXI address-channel FIFO (AW or AR) with first-word-fall-through.
// Ports:
//   clk, rst (async active-low)
//   push, entry_in          : write a packed request entry
//   pop                     : consume the head entry
//   flush                   : synchronous clear of contents and error flags
//   entry_out               : head entry, zero when empty
//   empty/full/almost_full  : occupancy decodes
//   count                   : occupancy
//   overflow/underflow      : sticky error flags
module axi_addr_fifo_n
  import axi_pkg::*;
#(
  parameter int unsigned TAG_BITS  = 2,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AF_THRESH = 3,
  localparam int unsigned ENTRY_W  = entry_w(TAG_BITS),
  localparam int unsigned PTR_W    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [ENTRY_W-1:0]       entry_in,
  input  logic                     pop,
  input  logic                     flush,
  output logic [ENTRY_W-1:0]       entry_out,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic               wr_en;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  fifo_ptr_ctrl #(
    .DEPTH     (DEPTH),
    .AF_THRESH (AF_THRESH)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .pop         (pop),
    .flush       (flush),
    .wr_en       (wr_en),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  // Storage is deliberately not reset; empty gates stale contents off the output.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr] <= entry_in;
  end

  always_comb begin
    entry_out = '0;
    if (!empty) entry_out = mem_q[rd_ptr];
  end

endmodule

// File: tb/tb_axi_addr_fifo_n.sv
module tb_axi_addr_fifo_n;

  logic        clk = 1'b0;
  logic        rst;
  logic        push, pop, flush;
  logic [63:0] ent;
  int          sel;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Instance 0: legacy shape (DEPTH 2, AF 2). 1: default. 2: deep, narrow tag.
  logic [50:0] eo0, eo1;
  logic [49:0] eo2;
  logic [1:0]  cnt0;
  logic [2:0]  cnt1;
  logic [3:0]  cnt2;
  logic        emp[3], ful[3], af[3], ov[3], un[3];
  logic [63:0] eo[3];
  logic [3:0]  cnt[3];

  axi_addr_fifo_n #(.TAG_BITS(2), .DEPTH(2), .AF_THRESH(2)) u_dut0 (
    .clk(clk), .rst(rst), .push(push && sel == 0), .entry_in(ent[50:0]),
    .pop(pop && sel == 0), .flush(flush), .entry_out(eo0), .empty(emp[0]),
    .full(ful[0]), .almost_full(af[0]), .count(cnt0), .overflow(ov[0]),
    .underflow(un[0]));

  axi_addr_fifo_n #(.TAG_BITS(2), .DEPTH(4), .AF_THRESH(3)) u_dut1 (
    .clk(clk), .rst(rst), .push(push && sel == 1), .entry_in(ent[50:0]),
    .pop(pop && sel == 1), .flush(flush), .entry_out(eo1), .empty(emp[1]),
    .full(ful[1]), .almost_full(af[1]), .count(cnt1), .overflow(ov[1]),
    .underflow(un[1]));

  axi_addr_fifo_n #(.TAG_BITS(1), .DEPTH(8), .AF_THRESH(6)) u_dut2 (
    .clk(clk), .rst(rst), .push(push && sel == 2), .entry_in(ent[49:0]),
    .pop(pop && sel == 2), .flush(flush), .entry_out(eo2), .empty(emp[2]),
    .full(ful[2]), .almost_full(af[2]), .count(cnt2), .overflow(ov[2]),
    .underflow(un[2]));

  assign eo[0]  = 64'(eo0);
  assign eo[1]  = 64'(eo1);
  assign eo[2]  = 64'(eo2);
  assign cnt[0] = 4'(cnt0);
  assign cnt[1] = 4'(cnt1);
  assign cnt[2] = cnt2;

  typedef struct {
    bit          push, pop, flush;
    logic [63:0] ent;
    int          cnt;
    bit          emp, full, af, ov, un;
    logic [63:0] out;
  } vec_t;

  vec_t        tbl[16];
  logic [63:0] e[16];

  function automatic logic [63:0] mk(input logic [1:0] id, input logic [31:0] addr);
    return 64'({id, addr, 4'h3, 2'h2, 2'h1, 2'h0, 4'h2, 3'h1});
  endfunction

  function automatic vec_t mkv(input bit pu, input bit po, input bit fl, input logic [63:0] en,
                               input int c, input bit em, input bit fu, input bit a,
                               input bit o, input bit u, input logic [63:0] out);
    vec_t v;
    v.push = pu; v.pop = po; v.flush = fl; v.ent = en; v.cnt = c;
    v.emp = em; v.full = fu; v.af = a; v.ov = o; v.un = u; v.out = out;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input int k, input string tag, input int c, input bit em,
                         input bit fu, input bit a, input bit o, input bit u,
                         input logic [63:0] out);
    chk({tag, " count"}, 64'(cnt[k]), 64'(c));
    chk({tag, " empty"}, 64'(emp[k]), 64'(em));
    chk({tag, " full"}, 64'(ful[k]), 64'(fu));
    chk({tag, " almost_full"}, 64'(af[k]), 64'(a));
    chk({tag, " overflow"}, 64'(ov[k]), 64'(o));
    chk({tag, " underflow"}, 64'(un[k]), 64'(u));
    chk({tag, " entry_out"}, eo[k], out);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic random_run(input int k, input int depth, input int afth, input int width);
    logic [63:0] q[$];
    logic [63:0] mask;
    bit          m_ov, m_un, pop_ok, push_ok;
    mask = (64'd1 << width) - 64'd1;
    sel = k; push = 0; pop = 0; flush = 1;
    step();
    flush = 0;
    m_ov = 0; m_un = 0;
    for (int c = 0; c < 10000; c++) begin
      push  = 1'($urandom_range(0, 1));
      pop   = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 199) == 0);
      ent   = {$urandom, $urandom} & mask;
      chk_all(k, $sformatf("rnd%0d c%0d", k, c), q.size(), q.size() == 0,
              q.size() == depth, q.size() >= afth, m_ov, m_un,
              (q.size() != 0) ? q[0] : 64'd0);
      if (flush) begin
        q.delete();
        m_ov = 0; m_un = 0;
      end else begin
        pop_ok  = pop && q.size() != 0;
        push_ok = push && (q.size() < depth || pop_ok);
        if (push && q.size() == depth && !pop_ok) m_ov = 1;
        if (pop && q.size() == 0) m_un = 1;
        if (pop_ok) void'(q.pop_front());
        if (push_ok) q.push_back(ent);
      end
      step();
    end
    push = 0; pop = 0; flush = 0;
  endtask

  initial begin
    for (int n = 0; n < 16; n++) e[n] = mk(2'(n), 32'h0000_1000 * n);

    //               pu po fl ent    cnt em fu af ov un out
    tbl[0]  = mkv(1, 0, 0, e[1], 1, 0, 0, 0, 0, 0, e[1]);
    tbl[1]  = mkv(1, 0, 0, e[2], 2, 0, 0, 0, 0, 0, e[1]);
    tbl[2]  = mkv(1, 0, 0, e[3], 3, 0, 0, 1, 0, 0, e[1]);
    tbl[3]  = mkv(1, 0, 0, e[4], 4, 0, 1, 1, 0, 0, e[1]);
    tbl[4]  = mkv(1, 1, 0, e[5], 4, 0, 1, 1, 0, 0, e[2]);
    tbl[5]  = mkv(1, 0, 0, e[6], 4, 0, 1, 1, 1, 0, e[2]);
    tbl[6]  = mkv(0, 1, 0, 0,    3, 0, 0, 1, 1, 0, e[3]);
    tbl[7]  = mkv(0, 1, 0, 0,    2, 0, 0, 0, 1, 0, e[4]);
    tbl[8]  = mkv(0, 1, 0, 0,    1, 0, 0, 0, 1, 0, e[5]);
    tbl[9]  = mkv(0, 1, 0, 0,    0, 1, 0, 0, 1, 0, 0);
    tbl[10] = mkv(0, 1, 0, 0,    0, 1, 0, 0, 1, 1, 0);
    tbl[11] = mkv(0, 0, 1, 0,    0, 1, 0, 0, 0, 0, 0);
    tbl[12] = mkv(1, 0, 1, e[7], 0, 1, 0, 0, 0, 0, 0);
    tbl[13] = mkv(1, 0, 0, e[7], 1, 0, 0, 0, 0, 0, e[7]);
    tbl[14] = mkv(0, 1, 1, 0,    0, 1, 0, 0, 0, 0, 0);
    tbl[15] = mkv(0, 1, 1, 0,    0, 1, 0, 0, 0, 0, 0);

    rst = 0; push = 0; pop = 0; flush = 0; ent = '0; sel = 1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1;
    step();
    for (int k = 0; k < 3; k++)
      chk_all(k, $sformatf("reset%0d", k), 0, 1, 0, 0, 0, 0, 0);

    sel = 1;
    for (int i = 0; i < 16; i++) begin
      push = tbl[i].push; pop = tbl[i].pop; flush = tbl[i].flush; ent = tbl[i].ent;
      step();
      chk_all(1, $sformatf("vec%0d", i), tbl[i].cnt, tbl[i].emp, tbl[i].full,
              tbl[i].af, tbl[i].ov, tbl[i].un, tbl[i].out);
    end
    push = 0; pop = 0; flush = 0;

    // Wrap-around: hold count at 2 while streaming 10 push+pop cycles.
    push = 1; ent = e[0]; step();
    ent = e[1]; step();
    chk("wrap fill count", 64'(cnt[1]), 64'd2);
    for (int i = 0; i < 10; i++) begin
      push = 1; pop = 1; ent = e[i + 2];
      step();
      chk($sformatf("wrap%0d count", i), 64'(cnt[1]), 64'd2);
      chk($sformatf("wrap%0d out", i), eo[1], e[i + 1]);
      chk($sformatf("wrap%0d ov", i), 64'(ov[1]), 64'd0);
    end
    push = 0; pop = 1; step();
    chk("wrap drain out", eo[1], e[11]);
    step();
    chk("wrap drain empty", 64'(emp[1]), 64'd1);
    chk("wrap drain un", 64'(un[1]), 64'd0);
    pop = 0;

    // Asynchronous reset mid-stream after three pushes.
    push = 1;
    for (int i = 0; i < 3; i++) begin ent = e[i + 8]; step(); end
    push = 0;
    chk("pre-reset count", 64'(cnt[1]), 64'd3);
    #2 rst = 0;
    #1;
    chk_all(1, "async reset", 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk) rst = 1;
    step();
    chk_all(1, "post reset", 0, 1, 0, 0, 0, 0, 0);

    random_run(0, 2, 2, 51);
    random_run(1, 4, 3, 51);
    random_run(2, 8, 6, 50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
